// File: rtl/note_rng_pkg.sv
// note_rng_pkg
//   Shared definitions for the note generator bank: the request mode
//   encoding, the sequencer state encoding, the LFSR reset seed and the
//   LFSR tap mask with its feedback helper.
package note_rng_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM     = 2'd0,
    MODE_WALK       = 2'd1,
    MODE_HOLD       = 2'd2,
    MODE_RANDOM_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  // The tap set is fixed, so the LFSR width is fixed with it.
  localparam int          LFSR_W_FIXED      = 16;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hA455;
  // Taps at bits 15,13,12,10 (one-based 16,14,13,11).
  localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;

  // XNOR feedback: all-zero is a legal state, all-ones is the lockup state.
  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ~(^(s & LFSR_TAP_MASK));
  endfunction

endpackage

// File: rtl/note_lfsr.sv
// note_lfsr
//   Master 16-bit XNOR LFSR, shifting left with feedback into bit 0.
//   A load has priority over a step; loading the all-ones lockup value
//   substitutes the reset seed.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset (state <= reset seed)
//   step      advance one position this cycle
//   load      load load_val this cycle (wins over step)
//   load_val  value to load
//   state     current LFSR contents
module note_lfsr
  import note_rng_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  if (LFSR_W != LFSR_W_FIXED) begin : g_width_check
    $error("note_lfsr: LFSR_W must be 16 (fixed tap set)");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LFSR_SEED_DEFAULT;
    end else if (load) begin
      state <= (&load_val) ? LFSR_SEED_DEFAULT : load_val;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], lfsr_feedback(state)};
    end
  end

endmodule

// File: rtl/note_rng_bank.sv
// note_rng_bank
//   Bank of NCH note registers refreshed one channel per cycle from a
//   shared LFSR. A request starts a generation pass (GEN) that writes
//   channel 0 .. NCH-1 in order, then the set is presented (VALID) until
//   the consumer accepts it.
//   Modes (sampled when GEN is entered):
//     random : low NOTE_W LFSR bits, folded once into 0..NOTE_MAX
//     walk   : +1 / -1 on LFSR bit 0, saturating at 0 and NOTE_MAX
//     hold   : value unchanged, sequencing still runs
//   Optional build macro NOTE_RNG_NO_REPEAT_EN: a random result equal to
//   the channel's previous value is bumped by one (NOTE_MAX wraps to 0).
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   en           global enable; low freezes LFSR and sequencer
//   req          single-cycle request for a new note set
//   mode         0 random, 1 walk, 2 hold, 3 random
//   seed_load    load seed into the LFSR (IDLE / VALID only)
//   seed         seed value
//   note_ready   consumer accepts the presented set
//   note_valid   note set stable and presented
//   busy         generation pass in progress
//   note         channel c at [c*NOTE_W +: NOTE_W]
module note_rng_bank
  import note_rng_pkg::*;
#(
  parameter int LFSR_W   = 16,
  parameter int NOTE_W   = 6,
  parameter int NCH      = 4,
  parameter int NOTE_MAX = 47
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  req,
  input  logic [1:0]            mode,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed,
  input  logic                  note_ready,
  output logic                  note_valid,
  output logic                  busy,
  output logic [NCH*NOTE_W-1:0] note
);

  localparam int                CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NCH - 1);
  localparam logic [NOTE_W-1:0] NMAX    = NOTE_W'(NOTE_MAX);
  // Zero when the range fills NOTE_W bits; the fold never fires then.
  localparam logic [NOTE_W-1:0] NSPAN   = NOTE_W'(NOTE_MAX + 1);

  if (NCH < 1 || NCH > 8) begin : g_nch_check
    $error("note_rng_bank: NCH must be in 1..8");
  end
  if (!(((1 << (NOTE_W - 1)) <= (NOTE_MAX + 1)) &&
        ((NOTE_MAX + 1) <= (1 << NOTE_W)))) begin : g_range_check
    $error("note_rng_bank: NOTE_MAX+1 must lie in [2^(NOTE_W-1), 2^NOTE_W]");
  end

  // Single subtraction is enough because NOTE_MAX+1 >= 2^(NOTE_W-1).
  function automatic logic [NOTE_W-1:0] fold_rand(input logic [NOTE_W-1:0] cand);
    if (cand > NMAX) return cand - NSPAN;
    return cand;
  endfunction

  function automatic logic [NOTE_W-1:0] walk_sat(input logic [NOTE_W-1:0] cur,
                                                 input logic              up);
    if (up) return (cur >= NMAX) ? NMAX : cur + NOTE_W'(1);
    return (cur == '0) ? '0 : cur - NOTE_W'(1);
  endfunction

`ifdef NOTE_RNG_NO_REPEAT_EN
  function automatic logic [NOTE_W-1:0] avoid_repeat(input logic [NOTE_W-1:0] nv,
                                                     input logic [NOTE_W-1:0] prev);
    if (nv != prev) return nv;
    return (nv == NMAX) ? '0 : nv + NOTE_W'(1);
  endfunction
`endif

  state_e             state, state_nx;
  logic               start_gen;
  logic [CH_W-1:0]    ch_idx;
  mode_e              mode_q;
  logic [NOTE_W-1:0]  notes_q [NCH];
  logic [LFSR_W-1:0]  lfsr_q;
  logic               lfsr_load;
  logic [NOTE_W-1:0]  cur_note, rand_note, next_note;

  // Only the low NOTE_W bits feed the notes; the rest just keep the
  // sequence long.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:NOTE_W];

  assign lfsr_load = en & seed_load & (state != ST_GEN);

  note_lfsr #(
    .LFSR_W(LFSR_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step    (en),
    .load    (lfsr_load),
    .load_val(seed),
    .state   (lfsr_q)
  );

  // Sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Sequencer: next state and outputs; a req that is not acted on is dropped
  always_comb begin
    state_nx   = state;
    start_gen  = 1'b0;
    busy       = (state == ST_GEN);
    note_valid = (state == ST_VALID);
    if (en) begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            state_nx  = ST_GEN;
            start_gen = 1'b1;
          end
        end
        ST_GEN: begin
          if (ch_idx == CH_LAST) state_nx = ST_VALID;
        end
        ST_VALID: begin
          if (note_ready) begin
            if (req) begin
              state_nx  = ST_GEN;
              start_gen = 1'b1;
            end else begin
              state_nx  = ST_IDLE;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Candidate value for the channel being written this cycle
  always_comb begin
    cur_note  = notes_q[ch_idx];
    rand_note = fold_rand(lfsr_q[NOTE_W-1:0]);
`ifdef NOTE_RNG_NO_REPEAT_EN
    rand_note = avoid_repeat(rand_note, cur_note);
`endif
    unique case (mode_q)
      MODE_WALK: next_note = walk_sat(cur_note, lfsr_q[0]);
      MODE_HOLD: next_note = cur_note;
      default:   next_note = rand_note;
    endcase
  end

  // Channel write / index / mode capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_idx <= '0;
      mode_q <= MODE_RANDOM;
      for (int c = 0; c < NCH; c++) notes_q[c] <= '0;
    end else if (en) begin
      if (start_gen) begin
        ch_idx <= '0;
        mode_q <= mode_e'(mode);
      end else if (state == ST_GEN) begin
        notes_q[ch_idx] <= next_note;
        ch_idx          <= (ch_idx == CH_LAST) ? '0 : ch_idx + CH_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_note
    assign note[c*NOTE_W +: NOTE_W] = notes_q[c];
  end

endmodule

// File: tb/tb_note_rng_bank.sv
// tb_note_rng_bank
//   Directed bench for note_rng_bank with a reference model of the LFSR and
//   note update rules. Expected note sets are queued when a request is
//   issued and popped when note_valid is observed.
//   Honours NOTE_RNG_NO_REPEAT_EN the same way as the design.
module tb_note_rng_bank;

  localparam int NW   = 6;
  localparam int NCH  = 4;
  localparam int NMAX = 47;
  localparam logic [15:0] SEED_DEF = 16'hA455;

  logic              clk = 1'b0;
  logic              rst, en, req, seed_load, note_ready;
  logic [1:0]        mode;
  logic [15:0]       seed;
  logic              note_valid, busy;
  logic [NCH*NW-1:0] note;

  int total = 0;
  int bad   = 0;

  logic [NW-1:0]     mdl [NCH];
  logic [NCH*NW-1:0] sb [$];

  note_rng_bank #(.LFSR_W(16), .NOTE_W(NW), .NCH(NCH), .NOTE_MAX(NMAX)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .mode(mode),
    .seed_load(seed_load), .seed(seed), .note_ready(note_ready),
    .note_valid(note_valid), .busy(busy), .note(note)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic fb;
    fb = ~(s[15] ^ s[13] ^ s[12] ^ s[10]);
    return {s[14:0], fb};
  endfunction

  function automatic logic [NW-1:0] m_note(input logic [1:0] m, input logic [NW-1:0] prev,
                                           input logic [15:0] l);
    int v;
    case (m)
      2'd1: begin
        v = l[0] ? int'(prev) + 1 : int'(prev) - 1;
        if (v > NMAX) v = NMAX;
        if (v < 0) v = 0;
      end
      2'd2: v = int'(prev);
      default: begin
        v = int'(l[NW-1:0]);
        if (v > NMAX) v = v - (NMAX + 1);
`ifdef NOTE_RNG_NO_REPEAT_EN
        if (v == int'(prev)) v = (v == NMAX) ? 0 : v + 1;
`endif
      end
    endcase
    return NW'(v);
  endfunction

  // One full transaction from IDLE: seed load, request, generation,
  // optional stall in VALID, then acceptance.
  task automatic do_set(input logic [1:0] m, input logic [15:0] s, input int pause,
                        input bit gen_load, input int stall);
    logic [15:0]       l;
    logic [NCH*NW-1:0] expv, held, got;
    int                bcnt;
    bit                seen, paused;
    seed_load = 1'b1; seed = s;
    cyc();
    seed_load = 1'b0;
    l = (s == 16'hFFFF) ? SEED_DEF : s;
    for (int c = 0; c < NCH; c++) begin
      l = m_next(l);
      mdl[c] = m_note(m, mdl[c], l);
      expv[c*NW +: NW] = mdl[c];
    end
    sb.push_back(expv);
    req = 1'b1; mode = m;
    cyc();
    req = 1'b0; mode = m + 2'd1;
    bcnt = 0; seen = 1'b0; paused = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (note_valid) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        seed_load = gen_load && (bcnt == 1);
        seed = 16'h1234;
        if (bcnt == 2 && pause > 0 && !paused) begin
          paused = 1'b1; en = 1'b0;
          repeat (pause) begin cyc(); if (busy) bcnt++; end
          en = 1'b1;
        end
        cyc();
      end
    end
    seed_load = 1'b0;
    chk("valid_timeout", note_valid, 1);
    chk("busy_cycles", bcnt, NCH + pause);
    chk("busy_in_valid", busy, 0);
    expv = sb.pop_front();
    chk("note_set", note, expv);
    for (int c = 0; c < NCH; c++) begin
      got = note;
      chk("note_range", got[c*NW +: NW] <= NW'(NMAX), 1);
    end
    if (stall > 0) begin
      held = note;
      for (int i = 0; i < stall; i++) begin
        req = (i % 3 == 0);
        cyc();
        chk("stall_note", note, held);
        chk("stall_valid", note_valid, 1);
      end
      req = 1'b0;
    end
    note_ready = 1'b1;
    cyc();
    note_ready = 1'b0;
    chk("accept_valid", note_valid, 0);
    chk("accept_busy", busy, 0);
  endtask

  initial begin
    logic [15:0]       ml;
    logic [NCH*NW-1:0] all47, prev;
    int                reps;
    rst = 1'b1; en = 1'b0; req = 1'b0; mode = 2'd0;
    seed_load = 1'b0; seed = '0; note_ready = 1'b0;
    for (int c = 0; c < NCH; c++) mdl[c] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_note", note, 0);
    chk("rst_valid", note_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr", dut.u_lfsr.state, SEED_DEF);
    rst = 1'b0;
    cyc();
    chk("lfsr_frozen", dut.u_lfsr.state, SEED_DEF);

    // Free-running LFSR sequence from the reset seed
    en = 1'b1;
    ml = SEED_DEF;
    cyc(); ml = m_next(ml);
    chk("lfsr_step1", dut.u_lfsr.state, 16'h48AA);
    for (int i = 0; i < 2; i++) begin
      cyc(); ml = m_next(ml);
      chk("lfsr_seq", dut.u_lfsr.state, ml);
    end
    chk("idle_notes", note, 0);

    // Lockup seed is replaced by the reset seed
    seed_load = 1'b1; seed = 16'hFFFF;
    cyc();
    seed_load = 1'b0;
    chk("lockup_seed", dut.u_lfsr.state, SEED_DEF);

    // Random mode, both encodings, lockup seed, pause/ignored-load/stall
    do_set(2'd0, 16'h1ACE, 0, 1'b0, 0);
    do_set(2'd3, 16'hBEEF, 0, 1'b0, 0);
    do_set(2'd0, 16'hFFFF, 0, 1'b0, 0);
    do_set(2'd0, 16'h5A5A, 3, 1'b1, 10);

    // Walk up with seed 0 (bit 0 = 1 every step) until saturated at top
    repeat (50) do_set(2'd1, 16'h0000, 0, 1'b0, 0);
    all47 = {NCH{6'd47}};
    chk("walk_sat_top", note, all47);
    // Walk down with seed 0x4400 (bit 0 = 0 every step) to the floor
    repeat (50) do_set(2'd1, 16'h4400, 0, 1'b0, 0);
    chk("walk_sat_bot", note, 0);

    do_set(2'd0, 16'h2468, 0, 1'b0, 0);
    do_set(2'd2, 16'h1357, 0, 1'b0, 0);

    // Reset in the middle of a generation pass
    req = 1'b1; mode = 2'd0;
    cyc();
    req = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_note", note, 0);
    chk("midrst_lfsr", dut.u_lfsr.state, SEED_DEF);
    for (int c = 0; c < NCH; c++) mdl[c] = '0;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("midrst_novalid", note_valid, 0);
      cyc();
    end
    chk("midrst_idle", busy, 0);

    // Repeat behaviour over many random sets
    reps = 0;
    for (int n = 0; n < 300; n++) begin
      prev = note;
      do_set(2'd0, 16'($urandom_range(0, 65535)), 0, 1'b0, 0);
      for (int c = 0; c < NCH; c++)
        if (note[c*NW +: NW] == prev[c*NW +: NW]) reps++;
    end
`ifdef NOTE_RNG_NO_REPEAT_EN
    chk("no_repeats", reps, 0);
`else
    chk("repeats_seen", reps > 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
